// File: rtl/sdr_rate_pkg.sv
// sdr_rate_pkg: shared fill-mode constants and rate-converter state encoding
package sdr_rate_pkg;
   localparam int MODE_ZERO_STUFF = 0;
   localparam int MODE_HOLD       = 1;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/interpolator.sv
// interpolator: integer-ratio upsampler emitting R outputs per accepted sample
module interpolator
   import sdr_rate_pkg::*;
#(
   parameter int W    = 16,
   parameter int R    = 5,
   parameter int RW   = 32,
   parameter int MODE = 0
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_ce,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   input  logic         i_clr_underrun,
   output logic         o_ready,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic         o_underrun
);
   localparam logic [RW-1:0] R_LAST = RW'(R);
   state_t        state_q, state_d;
   logic [RW-1:0] phase_q, phase_d;
   logic [W-1:0]  pend_q, pend_d, cur_q, cur_d, data_q, data_d, fill;
   logic          full_q, full_d, valid_q, valid_d, und_q, und_d, load;
   assign fill    = (MODE == MODE_HOLD) ? cur_q : '0;
   // a frame boundary is either the first strobe after idle or phase wrapping at R
   assign load    = i_ce && full_q && (state_q == IDLE || phase_q == R_LAST);
   assign o_ready = !full_q;
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_underrun = und_q;
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      full_d  = full_q;
      cur_d   = cur_q;
      data_d  = data_q;
      valid_d = 1'b0;
      und_d   = und_q && !i_clr_underrun;
      if (i_valid && !full_q) begin
         pend_d = i_data;
         full_d = 1'b1;
      end
      if (load) begin
         cur_d   = pend_q;
         full_d  = 1'b0;
         phase_d = RW'(1);
         data_d  = pend_q;
         valid_d = 1'b1;
         state_d = RUN;
      end else if (i_ce && state_q == RUN) begin
         valid_d = 1'b1;
         data_d  = fill;
         phase_d = (phase_q == R_LAST) ? RW'(1) : phase_q + RW'(1);
         und_d   = und_d || (phase_q == R_LAST);
      end
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         pend_q  <= '0;
         full_q  <= 1'b0;
         cur_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         full_q  <= full_d;
         cur_q   <= cur_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         und_q   <= und_d;
      end
   end
endmodule

// File: tb/tb_interpolator.sv
// tb_interpolator: zero-stuff and hold instances checked against a frame-level model
module tb_interpolator;
   localparam int R = 4;
   logic clk = 0, rst_n = 0, ce = 0, valid = 0, clr = 0;
   logic [15:0] din = 0, d0, d1;
   logic rdy0, rdy1, v0, v1, u0, u1;
   int checks = 0, errors = 0;
   logic [15:0] pend[$], txq[$], log0[$], log1[$];
   logic [15:0] cur = 0, ed0 = 0, ed1 = 0;
   bit started = 0, ev = 0, eu = 0;
   int k = 0;

   interpolator #(.W(16), .R(R), .RW(32), .MODE(0)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(din), .i_valid(valid),
      .i_clr_underrun(clr), .o_ready(rdy0), .o_data(d0), .o_valid(v0), .o_underrun(u0));
   interpolator #(.W(16), .R(R), .RW(32), .MODE(1)) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(din), .i_valid(valid),
      .i_clr_underrun(clr), .o_ready(rdy1), .o_data(d1), .o_valid(v1), .o_underrun(u1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete(); txq.delete(); log0.delete(); log1.delete();
      cur = 0; started = 0; k = 0; ev = 0; eu = 0; ed0 = 0; ed1 = 0;
   endtask

   // one clock: each accepted sample yields itself then R-1 fills; a missing successor is an underrun
   task automatic cycle(input bit c, input bit cl);
      bit acc, und_ev;
      und_ev = 0;
      ce = c; clr = cl;
      valid = (txq.size() > 0);
      din = valid ? txq[0] : 16'h0;
      acc = valid && (pend.size() == 0);
      ev = 0;
      if (c) begin
         if (started && k < R) begin
            ev = 1; ed0 = 0; ed1 = cur; k++;
         end else if (pend.size() > 0) begin
            cur = pend.pop_front(); ev = 1; ed0 = cur; ed1 = cur; started = 1; k = 1;
         end else if (started) begin
            ev = 1; ed0 = 0; ed1 = cur; und_ev = 1; k = 1;
         end
      end
      eu = (eu && !cl) || und_ev;
      if (acc) begin
         pend.push_back(din);
         void'(txq.pop_front());
      end
      @(posedge clk); #1;
      chk("valid0", v0, ev);
      chk("valid1", v1, ev);
      chk("data0", d0, ed0);
      chk("data1", d1, ed1);
      chk("ready0", rdy0, pend.size() == 0);
      chk("ready1", rdy1, pend.size() == 0);
      chk("under0", u0, eu);
      chk("under1", u1, eu);
      if (v0) log0.push_back(d0);
      if (v1) log1.push_back(d1);
   endtask

   task automatic run(input int n, input int per);
      for (int i = 0; i < n; i++) cycle((i % per) == per - 1, 1'b0);
   endtask

   task automatic mid_reset();
      #3 rst_n = 0;
      #1;
      chk("rst_valid", {v0, v1}, 2'b00);
      chk("rst_data", {d0, d1}, 32'h0);
      chk("rst_under", {u0, u1}, 2'b00);
      chk("rst_ready", {rdy0, rdy1}, 2'b11);
      model_reset();
      ce = 0; valid = 0; clr = 0; din = 0;
      @(posedge clk); #1 rst_n = 1;
   endtask

   initial begin
      logic [15:0] e36[8];
      logic [15:0] e37[8];
      e36 = '{16'd100, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0, 16'd0, 16'd0};
      e37 = '{16'hFFF9, 16'hFFF9, 16'hFFF9, 16'hFFF9, 16'd25, 16'd25, 16'd25, 16'd25};
      @(posedge clk); #1;
      chk("init_data", {d0, d1}, 32'h0);
      chk("init_ready", {rdy0, rdy1}, 2'b11);
      chk("init_valid", {v0, v1}, 2'b00);
      rst_n = 1;
      txq = '{16'd100, 16'd200};
      run(9, 1);
      chk("s36_cnt", log0.size(), 8);
      for (int i = 0; i < 8 && i < log0.size(); i++) chk("s36_seq", log0[i], e36[i]);
      chk("s36_under", u0, 1'b0);
      mid_reset();
      txq = '{16'hFFF9, 16'd25};
      run(9, 1);
      chk("s37_cnt", log1.size(), 8);
      for (int i = 0; i < 8 && i < log1.size(); i++) chk("s37_seq", log1[i], e37[i]);
      mid_reset();
      txq = '{16'd5};
      run(6, 1);
      chk("s38_under", u0, 1'b1);
      cycle(1'b1, 1'b1);
      chk("s38_clr", u0, 1'b0);
      run(3, 1);
      mid_reset();
      txq = '{16'd9};
      run(20, 3);
      chk("s39_first", log0.size() > 0 ? log0[0] : 16'hDEAD, 16'd9);
      mid_reset();
      txq = '{16'd50, 16'd60};
      run(3, 1);
      chk("s40_full", rdy0, 1'b0);
      mid_reset();
      run(10, 1);
      chk("s40_silent", log0.size() + log1.size(), 0);
      mid_reset();
      for (int i = 0; i < 600; i++) begin
         if (txq.size() == 0 && $urandom_range(0, 3) == 0) txq.push_back(16'($urandom));
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/interpolator.md
INTERPOLATOR -- requirements
Module: interpolator

Interface
REQ-001 Parameter W, default 16: sample width in bits, signed two's complement.
REQ-002 Parameter R, default 5: interpolation ratio, legal range 2..2^RW-1.
REQ-003 Parameter RW, default 32: phase counter width.
REQ-004 Parameter MODE, default 0: 0 = zero-stuff, 1 = zero-order hold.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_ce  input  1  output-rate strobe; one output sample per high cycle.
REQ-008 i_data  input  W  signed input sample.
REQ-009 i_valid  input  1  i_data is valid.
REQ-010 o_ready  output  1  pending slot empty; sample accepted when i_valid && o_ready.
REQ-011 o_data  output  W  signed output sample, registered.
REQ-012 o_valid  output  1  one-cycle pulse per output sample.
REQ-013 o_underrun  output  1  sticky flag: a frame boundary found no pending sample.
REQ-014 i_clr_underrun  input  1  synchronous clear of o_underrun.

Function
REQ-015 Storage: one pending register (sample + full flag) and one current register (sample); no other buffering.
REQ-016 o_ready SHALL equal NOT pending-full, registered, with no combinational path from i_ce or i_valid.
REQ-017 Accept on i_valid && o_ready: pending <= i_data, full <= 1 at the next edge.
REQ-018 States IDLE, RUN; reset enters IDLE.
REQ-019 IDLE: o_valid = 0; on i_ce with pending full: current <= pending, full <= 0, phase <= 1, emit pending sample, go RUN.
REQ-020 IDLE with i_ce and pending empty: no output, no underrun, stay IDLE.
REQ-021 RUN, i_ce, phase < R: emit 0 (MODE 0) or current (MODE 1); phase <= phase + 1.
REQ-022 RUN, i_ce, phase == R, pending full: load current, clear full, emit new sample, phase <= 1.
REQ-023 RUN, i_ce, phase == R, pending empty: emit 0 (MODE 0) or current (MODE 1), set o_underrun, phase <= 1, stay RUN.
REQ-024 Phase compare uses RW-bit unsigned arithmetic; phase SHALL never exceed R.
REQ-025 Latency: o_data/o_valid update at the edge that samples i_ce = 1; o_valid is high for exactly that following cycle.
REQ-026 i_ce low: o_valid = 0, o_data holds, phase and state frozen; input acceptance continues.
REQ-027 Load and accept in the same cycle cannot occur: o_ready is 0 while pending is full.
REQ-028 Each accepted sample SHALL produce exactly R outputs, the first being the sample itself; no sample is dropped.
REQ-029 i_clr_underrun coincident with a new underrun event: set wins.

Reset
REQ-030 On i_reset_n low: o_data = 0, o_valid = 0, o_underrun = 0, o_ready = 1, pending/current = 0, full = 0, phase = 0, state IDLE.
REQ-031 Reset mid-frame SHALL drop the pending and current samples immediately; no further outputs from them.
REQ-032 Output resumes only after a new sample is accepted following reset release.

Structure
REQ-033 Shared package sdr_rate_pkg holds MODE_ZERO_STUFF = 0, MODE_HOLD = 1, and the IDLE/RUN state encoding.
REQ-034 Single module; no sub-module.

Verification (W = 16, R = 4, i_ce = 1 every cycle unless stated)
REQ-035 Reset: pulse i_reset_n low mid-cycle -> all outputs 0 asynchronously, o_ready = 1 after release.
REQ-036 MODE 0, accept 100 then 200 back-to-back -> o_data 100,0,0,0,200,0,0,0 on 8 consecutive o_valid pulses; o_underrun = 0.
REQ-037 MODE 1, accept -7 then 25 -> -7 x4 then 25 x4; o_ready returns 1 one cycle after each load.
REQ-038 MODE 0, accept 5 only -> 5,0,0,0,0,... ; o_underrun = 1 after the 4th output; i_clr_underrun pulse -> 0.
REQ-039 i_ce high every 3rd cycle, accept 9 -> o_valid only in the cycle after each strobe, exactly 4 outputs for the sample.
REQ-040 Reset asserted at phase 2 of sample 50 with 60 pending -> o_valid = 0 immediately; after release no 50/60 output appears.
